sad_sequencer: RTL and testbench
================================

Name: sad_sequencer

Overview:
- Multi-cycle sum-of-absolute-differences engine built around one shared nBitAdder instance of width SIZE.
- Every arithmetic step goes through that single adder: subtract, fix-up increment, accumulate low half, accumulate high half.
- Accepts COUNT operand pairs per job over a valid/ready stream and returns a 2*SIZE-bit SAD on a valid/ready result port.
- Sits beside the AbsDiff datapath as its controller and scheduler.

Parameters:
- SIZE, 8: operand width; must be even (adder constraint).
- COUNT, 4: pairs per job; must be >= 1.
- CNT_W, 8: width of the internal pair counter; requires COUNT < 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  job start pulse; sampled only in IDLE.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  high only in WAIT_PAIR.
- a  input  SIZE  operand A, unsigned.
- b  input  SIZE  operand B, unsigned.
- out_valid  output  1  high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sad  output  2*SIZE  accumulated result; holds its value in DONE.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; acc, count, ra, rb, t, d, gt all cleared. Resulting outputs: in_ready=0, out_valid=0, sad=0, busy=0.
- Reset mid-job: abandons the job; no partial result is ever flagged valid.
- Adder muxing:
  - One nBitAdder (SIZE); operand mux select is driven by state.
  - Adder inputs in IDLE, WAIT_PAIR and DONE: 0, 0.
- IDLE:
  - start=1: acc<=0, count<=0, go to WAIT_PAIR.
  - start in any other state is ignored.
- WAIT_PAIR:
  - in_valid & in_ready: ra<=a, rb<=b, go to SUB.
  - Otherwise hold.
- SUB:
  - Adder(ra, ~rb). t<=sum, which equals A-B-1 mod 2^SIZE; gt<=carryOut, which is 1 iff A>B.
  - gt: go to FIX.
  - else: d<=~sum (= B-A, and 0 when A==B), go to ACC_LO.
- FIX: adder(t, 1); d<=sum; go to ACC_LO.
- ACC_LO: adder(acc[SIZE-1:0], d); acc low half<=sum; c<=carryOut; go to ACC_HI.
- ACC_HI:
  - Adder(acc[2*SIZE-1:SIZE], {0..,c}); acc high half<=sum (carry-out discarded; wraps mod 2^(2*SIZE)); count<=count+1.
  - If count+1==COUNT: go to DONE. Else: go to WAIT_PAIR.
- DONE:
  - out_valid=1, sad=acc.
  - out_ready=1: go to IDLE (out_valid drops next cycle).
  - Result held indefinitely until accepted.
- sad is driven from acc in all states. Only the DONE value is meaningful.
- Per-pair latency from accept edge to next in_ready=1:
  - A>B: 4 cycles.
  - A<=B: 3 cycles.
- Last pair: out_valid rises in the cycle after ACC_HI.
- in_valid held high across pairs: the next pair is accepted on the first WAIT_PAIR cycle (zero bubble beyond the above).

Optional Feature:
- Macro: SAD_SKIP_HI_EN.
- Defined: in ACC_LO, if carryOut=0, skip ACC_HI and perform the count update and DONE/WAIT_PAIR decision in ACC_LO itself. Latency becomes 3/2 cycles (A>B / A<=B) when no low-half carry occurs.
- Undefined: ACC_HI is always visited; latencies as above.
- The sad value must be identical either way.

Test Plan:
- SIZE=8, COUNT=4, pairs (10,3),(3,10),(7,7),(255,0) -> sad=0x010D (269); out_valid exactly once; busy high from the cycle after start until the cycle after out_ready.
- Single pair (10,3), in_valid held high -> in_ready low for 4 cycles after accept; (3,10) -> low for 3 cycles. With SAD_SKIP_HI_EN -> 3 and 2 cycles.
- COUNT=1, pair (0,255) -> sad=0x00FF; out_ready held low 5 cycles -> out_valid and sad stable throughout.
- rst asserted during FIX of pair 2 -> next cycle all outputs 0, state IDLE; a new start with pairs (1,2) x4 -> sad=4.
- start pulsed while in WAIT_PAIR and in DONE -> ignored; acc and count unchanged.
- COUNT=4, four pairs (255,0) -> sad=0x03FC; high-half carry exercised on pairs 2-4.

Source files
------------

// File: rtl/sad_sequencer.sv
// rtl/sad_sequencer.sv - multi-cycle SAD engine sharing one nBitAdder (optional macro SAD_SKIP_HI_EN)

// Ripple adder built from 2-bit slices (hence the even-width requirement), carry-in tied to 0.
module nBitAdder #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] sum,
    output logic            carry_out
);
    localparam int SLICES = SIZE / 2;

    logic [SLICES:0] carry;

    assign carry[0]  = 1'b0;
    assign carry_out = carry[SLICES];

    for (genvar i = 0; i < SLICES; i++) begin : g_slice
        logic [2:0] part;
        assign part = {1'b0, a[2*i+1:2*i]} + {1'b0, b[2*i+1:2*i]} + {2'b00, carry[i]};
        assign sum[2*i+1:2*i] = part[1:0];
        assign carry[i+1]     = part[2];
    end
endmodule

// Scheduler: every subtract, fix-up, and accumulate step is time-multiplexed onto one adder.
module sad_sequencer #(
    parameter int SIZE  = 8,
    parameter int COUNT = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] sad,
    output logic              busy
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_PAIR,
        SUB,
        FIX,
        ACC_LO,
        ACC_HI,
        DONE
    } state_t;

    state_t            state;
    logic [2*SIZE-1:0] acc;
    logic [CNT_W-1:0]  count;
    logic [SIZE-1:0]   ra;
    logic [SIZE-1:0]   rb;
    logic [SIZE-1:0]   t;
    logic [SIZE-1:0]   d;
    logic              gt;
    logic              c;

    logic [SIZE-1:0]   add_a;
    logic [SIZE-1:0]   add_b;
    logic [SIZE-1:0]   add_sum;
    logic              add_carry;

    logic [CNT_W-1:0]  count_next;
    logic              last_pair;

    assign count_next = count + {{(CNT_W-1){1'b0}}, 1'b1};
    assign last_pair  = (count_next == CNT_W'(COUNT));
    assign sad        = acc;

    nBitAdder #(.SIZE(SIZE)) u_adder (
        .a         (add_a),
        .b         (add_b),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    // Adder operand mux, selected by the current state; idle states feed zeros.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            SUB: begin
                add_a = ra;
                add_b = ~rb;
            end
            FIX: begin
                // gt is always 1 here, so this is the +1 that turns A-B-1 into A-B.
                add_a = t;
                add_b = {{(SIZE-1){1'b0}}, gt};
            end
            ACC_LO: begin
                add_a = acc[SIZE-1:0];
                add_b = d;
            end
            ACC_HI: begin
                add_a = acc[2*SIZE-1:SIZE];
                add_b = {{(SIZE-1){1'b0}}, c};
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    // Control FSM with registered handshake and busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ra        <= '0;
            rb        <= '0;
            t         <= '0;
            d         <= '0;
            gt        <= 1'b0;
            c         <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        count    <= '0;
                        state    <= WAIT_PAIR;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WAIT_PAIR: begin
                    if (in_valid && in_ready) begin
                        ra       <= a;
                        rb       <= b;
                        state    <= SUB;
                        in_ready <= 1'b0;
                    end
                end
                SUB: begin
                    t  <= add_sum;
                    gt <= add_carry;
                    if (add_carry) begin
                        state <= FIX;
                    end else begin
                        d     <= ~add_sum;
                        state <= ACC_LO;
                    end
                end
                FIX: begin
                    d     <= add_sum;
                    state <= ACC_LO;
                end
                ACC_LO: begin
                    acc[SIZE-1:0] <= add_sum;
                    c             <= add_carry;
`ifdef SAD_SKIP_HI_EN
                    if (!add_carry) begin
                        count <= count_next;
                        if (last_pair) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= WAIT_PAIR;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        state <= ACC_HI;
                    end
`else
                    state <= ACC_HI;
`endif
                end
                ACC_HI: begin
                    acc[2*SIZE-1:SIZE] <= add_sum;
                    count              <= count_next;
                    if (last_pair) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state    <= WAIT_PAIR;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sad_sequencer.sv
// tb/tb_sad_sequencer.sv - self-checking bench for sad_sequencer
module tb_sad_sequencer;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid, out_ready;
    logic [7:0]  a, b;
    logic        in_ready, out_valid, busy;
    logic [15:0] sad;

    logic        start1, in_valid1, out_ready1;
    logic [7:0]  a1, b1;
    logic        in_ready1, out_valid1, busy1;
    logic [15:0] sad1;

    int checks = 0;
    int errors = 0;

`ifdef SAD_SKIP_HI_EN
    localparam int LAT_GT = 3;
    localparam int LAT_LE = 2;
`else
    localparam int LAT_GT = 4;
    localparam int LAT_LE = 3;
`endif

    sad_sequencer #(.SIZE(8), .COUNT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sad(sad), .busy(busy)
    );

    sad_sequencer #(.SIZE(8), .COUNT(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .sad(sad1), .busy(busy1)
    );

    typedef struct {
        logic [3:0][7:0] pa;
        logic [3:0][7:0] pb;
        logic [15:0]     exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one pair, wait for acceptance, then count cycles until in_ready or out_valid returns.
    task automatic send_pair(input logic [7:0] pa, input logic [7:0] pb, output int lat);
        int n;
        a = pa;
        b = pb;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!in_ready && !out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_out_valid"}, out_valid, 1);
    endtask

    task automatic accept_result(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_valid_drop"}, out_valid, 0);
        check({name, "_busy_drop"}, busy, 0);
    endtask

    task automatic run_job(input logic [3:0][7:0] va, input logic [3:0][7:0] vb,
                           input logic [15:0] exp, input string name);
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy"}, busy, 1);
        for (int i = 0; i < 4; i++) begin
            check({name, "_no_early_valid"}, out_valid, 0);
            send_pair(va[i], vb[i], lat);
        end
        wait_result(name);
        check({name, "_sad"}, sad, exp);
        accept_result(name);
    endtask

    function automatic logic [15:0] model_sad(input logic [3:0][7:0] va, input logic [3:0][7:0] vb);
        int total;
        total = 0;
        for (int i = 0; i < 4; i++)
            total += (va[i] > vb[i]) ? int'(va[i]) - int'(vb[i]) : int'(vb[i]) - int'(va[i]);
        return 16'(total);
    endfunction

    vec_t tbl[5];

    initial begin
        int lat;
        int n;
        logic [15:0] held;
        logic [3:0][7:0] ra, rb;

        tbl[0] = '{pa: {8'd255, 8'd7, 8'd3, 8'd10}, pb: {8'd0, 8'd7, 8'd10, 8'd3}, exp: 16'h010D};
        tbl[1] = '{pa: {8'd255, 8'd255, 8'd255, 8'd255}, pb: {8'd0, 8'd0, 8'd0, 8'd0}, exp: 16'h03FC};
        tbl[2] = '{pa: {8'd0, 8'd0, 8'd0, 8'd0}, pb: {8'd255, 8'd255, 8'd255, 8'd255}, exp: 16'h03FC};
        tbl[3] = '{pa: {8'd1, 8'd1, 8'd1, 8'd1}, pb: {8'd2, 8'd2, 8'd2, 8'd2}, exp: 16'd4};
        tbl[4] = '{pa: {8'd9, 8'd200, 8'd0, 8'd42}, pb: {8'd9, 8'd200, 8'd0, 8'd42}, exp: 16'd0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        start1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sad", sad, 0);
        check("rst_busy", busy, 0);
        check("rst1_busy", busy1, 0);

        // Latencies plus start ignored in WAIT_PAIR and in DONE.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_busy", busy, 1);
        send_pair(8'd10, 8'd3, lat);
        check("lat_gt", lat, LAT_GT);
        send_pair(8'd3, 8'd10, lat);
        check("lat_le", lat, LAT_LE);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_wait_ignored", in_ready, 1);
        send_pair(8'd7, 8'd7, lat);
        check("lat_eq", lat, LAT_LE);
        send_pair(8'd255, 8'd0, lat);
        wait_result("spec");
        check("spec_sad", sad, 16'h010D);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done_valid", out_valid, 1);
        check("start_in_done_sad", sad, 16'h010D);
        accept_result("spec");

        for (int i = 0; i < 5; i++)
            run_job(tbl[i].pa, tbl[i].pb, tbl[i].exp, $sformatf("tbl%0d", i));

        // Reset during FIX of pair 2, then a fresh job.
        start = 1'b1;
        tick();
        start = 1'b0;
        send_pair(8'd5, 8'd1, lat);
        a = 8'd9; b = 8'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sad", sad, 0);
        check("midrst_busy", busy, 0);
        run_job({8'd1, 8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2}, 16'd4, "post_rst");

        // Randomized jobs against the arithmetic model.
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: begin ra[i] = 8'd255; rb[i] = 8'($urandom); end
                    1: begin ra[i] = 8'($urandom); rb[i] = 8'd255; end
                    default: begin ra[i] = 8'($urandom); rb[i] = 8'($urandom); end
                endcase
            end
            run_job(ra, rb, model_sad(ra, rb), $sformatf("rnd%0d", j));
        end

        // COUNT=1 instance: result held while out_ready stays low.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        a1 = 8'd0; b1 = 8'd255; in_valid1 = 1'b1;
        n = 0;
        while (!in_ready1 && n < 50) begin tick(); n++; end
        tick();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 50) begin tick(); n++; end
        check("c1_out_valid", out_valid1, 1);
        held = sad1;
        check("c1_sad", held, 16'h00FF);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("c1_hold_valid", out_valid1, 1);
            check("c1_hold_sad", sad1, 16'h00FF);
        end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("c1_valid_drop", out_valid1, 0);
        check("c1_busy_drop", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
